count_capture_fifo: RTL
=======================

Name: count_capture_fifo

Overview:
- Downstream consumer of the free-running 32-bit cycle counter.
- Timestamps rising edges of an external event strobe by capturing the counter value into a small FIFO.
- The host drains the FIFO through a valid/ready interface.
- Used on the emulation DUT side to log event times without stalling the counter or the event source.

Parameters:
- WIDTH, 32, bit width of count_in and captured timestamps.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- count_in  input  WIDTH  free-running counter value, sampled same clock domain.
- event_in  input  1  event strobe; level signal, rising edges captured.
- ts_data  output  WIDTH  head-of-FIFO timestamp (show-ahead).
- ts_valid  output  1  FIFO non-empty; ts_data valid.
- ts_ready  input  1  consumer accepts head when ts_valid & ts_ready.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one event dropped.
- drop_cnt  output  DROP_W  saturating count of dropped events.
- ovf_clr  input  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (async, rst=1):
  - Pointers, level, ts_valid, overflow, drop_cnt, event_d all 0.
  - ts_data is don't-care while ts_valid=0.
- Edge detect:
  - event_d registers event_in each cycle.
  - edge = event_in & ~event_d.
  - event_in already high when rst deasserts counts as an edge on the first active cycle, since event_d resets to 0.
- Push: on a posedge with edge=1, the value of count_in sampled at that same posedge is written. ts_valid rises after that posedge, giving 1-cycle capture-to-visible latency.
- Pop: on a posedge with ts_valid & ts_ready, the head is removed. The next entry appears on ts_data after that edge.
- Handshake: ts_data and ts_valid are stable while ts_valid=1 & ts_ready=0. ts_ready is ignored when ts_valid=0.
- Full with edge and pop in the same cycle: push accepted, level unchanged, no overflow.
- Full with edge and no pop: event dropped, FIFO contents untouched, overflow set to 1.
- drop_cnt increments on each drop and saturates at 2^DROP_W-1.
- Empty with edge and ts_ready=1 in the same cycle: push accepted, no bypass; the entry becomes visible next cycle.
- level:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH, never underflows.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from level.
- Counter wrap: count_in wrapping from 0xFFFFFFFF to 0 needs no special handling; values are stored verbatim.
- ovf_clr:
  - Clears overflow and drop_cnt at the next posedge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- rst asserted mid-operation flushes all entries immediately; no partial pop is reported.

Optional Feature:
- Macro: COUNT_CAPTURE_DELTA_EN.
- Defined:
  - Each stored entry is (count_in - prev_ts) modulo 2^WIDTH.
  - prev_ts is a WIDTH-bit register, reset to 0, loaded with count_in only on accepted pushes.
  - Dropped events do not update prev_ts, so the sum of popped deltas equals the absolute time of the last accepted event.
  - The first capture after reset stores the absolute count_in.
- Undefined:
  - Absolute count_in is stored.
  - No prev_ts register or subtractor is present.

Test Plan:
- Single capture:
  - Stimulus: reset, count_in=100, event_in 0->1 at the edge where count_in=100, ts_ready=0.
  - Response: next cycle ts_valid=1, ts_data=100, level=1. Holding event_in high produces no further captures.
- Ordered drain:
  - Stimulus: edges at count 10, 20, 30, then ts_ready=1 continuously.
  - Response: ts_data 10, 20, 30 on consecutive cycles, then ts_valid=0, level=0.
- Overflow:
  - Stimulus: DEPTH=8, ts_ready=0, 10 edges at counts 1..10.
  - Response: level=8, overflow=1, drop_cnt=2, drained data 1..8.
  - Then pulse ovf_clr: overflow=0, drop_cnt=0.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, edge at count 50 with ts_ready=1.
  - Response: oldest entry popped, 50 appended, level stays 8, overflow=0.
- Wrap and reset:
  - Stimulus: edges at count 0xFFFFFFFE and 0x00000003. With COUNT_CAPTURE_DELTA_EN defined, the second entry is 5.
  - Stimulus: assert rst mid-drain.
  - Response: ts_valid=0 and level=0 immediately, without waiting for a clock.
- Delta mode with drops:
  - Stimulus: COUNT_CAPTURE_DELTA_EN defined, DEPTH=2, edges at 100, 150, 400 with no reads.
  - Response: entries 100 and 50; the 400 edge is dropped and prev_ts stays 150.
  - Stimulus: after one pop, edge at 500.
  - Response: stored entry is 350.

Source files
------------

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//
// Timestamps rising edges of an event strobe by capturing the free-running
// cycle counter into a small show-ahead FIFO that a host drains through a
// valid/ready interface. Neither the counter nor the event source is ever
// stalled: when the FIFO is full and nothing is leaving, the event is dropped
// and recorded in a sticky overflow flag and a saturating drop counter.
//
// Build option:
//   COUNT_CAPTURE_DELTA_EN - when defined, each entry holds the difference
//     between count_in and the previous accepted timestamp (modulo 2^WIDTH)
//     instead of the absolute counter value.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   asynchronous active-high reset
//   count_in  in   [WIDTH]   free-running counter value
//   event_in  in   event strobe (level), rising edges are captured
//   ts_data   out  [WIDTH]   head-of-FIFO timestamp (show-ahead)
//   ts_valid  out  FIFO non-empty
//   ts_ready  in   consumer accepts head when ts_valid & ts_ready
//   level     out  [$clog2(DEPTH)+1] occupancy 0..DEPTH
//   overflow  out  sticky, at least one event dropped
//   drop_cnt  out  [DROP_W]  saturating dropped-event count
//   ovf_clr   in   synchronous clear of overflow and drop_cnt
module count_capture_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       event_in,
  output logic [WIDTH-1:0]           ts_data,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;
  logic              event_d;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;

  logic              edge_det;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic [WIDTH-1:0]  wr_data;

  assign edge_det = event_in & ~event_d;
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign pop      = ~empty & ts_ready;
  // A full FIFO can still accept an edge when the head leaves on the same
  // clock; the write lands in the slot being vacated.
  assign push     = edge_det & (~full | pop);
  assign drop     = edge_det & full & ~pop;

`ifdef COUNT_CAPTURE_DELTA_EN
  logic [WIDTH-1:0] prev_ts;

  assign wr_data = count_in - prev_ts;

  // Only accepted pushes advance the reference, so the popped deltas always
  // sum to the absolute time of the last stored event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ts <= '0;
    end else if (push) begin
      prev_ts <= count_in;
    end
  end
`else
  assign wr_data = count_in;
`endif

  // Storage needs no reset: ts_data is only meaningful while ts_valid=1.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_d <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      event_d <= event_in;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // A drop in the same cycle as ovf_clr wins and restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (ovf_clr) begin
        drop_q <= DROP_W'(1);
      end else if (drop_q != {DROP_W{1'b1}}) begin
        drop_q <= drop_q + DROP_W'(1);
      end
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

  assign ts_data  = mem[rd_ptr];
  assign ts_valid = ~empty;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule
